rom_loader: RTL
===============

# rom_loader

Byte-stream consumer placed directly downstream of the SPI flash read engine. Accepts the received flash bytes one strobe at a time and writes them sequentially into the C64 ROM block RAM (KERNAL/BASIC/CHARGEN image). Holds the 6510 in reset until the whole image is resident, then signals completion.

## Interface
Parameters:
- ADDR_W, 14, width of the memory write address (16 KB window).
- IMAGE_BYTES, 16384, number of image bytes to copy; must be in the range 1 to 2^ADDR_W.
- BASE_ADDR, 0, first memory address written; the address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load.
- byte_data  in  8  received flash byte.
- byte_valid  in  1  one-cycle strobe; byte_data is valid in the same cycle.
- mem_addr  out  ADDR_W  RAM write address.
- mem_data  out  8  RAM write data.
- mem_we  out  1  RAM write enable, one cycle per byte.
- busy  out  1  high while a load is in progress.
- done  out  1  high from load completion until the next start.
- cpu_hold  out  1  high holds the CPU in reset.
- chk_err  out  1  checksum mismatch flag; valid when done is high.

## Operation
- States: IDLE, LOAD, CHECK (only when the macro is defined), DONE.
- IDLE: byte_valid is ignored. start moves to LOAD, clears the byte count and checksum, sets busy=1 and done=0.
- LOAD: each byte_valid registers byte_data and writes it to BASE_ADDR+count, then increments count. The 15-bit count covers the full IMAGE_BYTES range. When count reaches IMAGE_BYTES, the block moves to CHECK if the macro is defined, otherwise to DONE.
- CHECK: the next byte_valid is the trailer byte and is not written to RAM. chk_err is set to 1 if (sum of image bytes + trailer) mod 256 is not 0. The block then moves to DONE.
- DONE: busy=0, done=1, cpu_hold=0. Surplus byte_valid strobes are ignored with no RAM write. start restarts the load: the block moves to LOAD, cpu_hold returns to 1, and chk_err clears.
- start while in LOAD or CHECK is ignored.
- Reset values: state=IDLE, mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, cpu_hold=1, chk_err=0.
- Reset asserted mid-load aborts the load and returns the block to IDLE with the reset values. Partially written RAM is left as is.

## Timing
- Write latency: byte_valid in cycle n gives mem_we=1 in cycle n+1, with mem_addr and mem_data held for that cycle. mem_we is 0 in every other cycle.
- Back-to-back byte_valid on consecutive cycles is supported: one write per cycle, no loss. No back-pressure exists.
- The last image byte's write cycle is n+1. done and cpu_hold=0 take effect in cycle n+2.
- With the checksum enabled, a trailer strobe in cycle m gives done and chk_err in cycle m+1.
- start in cycle k makes busy=1 in cycle k+1. byte_valid in cycle k itself is ignored.
- start and byte_valid in the same cycle while in IDLE or DONE: start takes effect and the byte is dropped.

## Configuration
- ROM_LOADER_CHECKSUM_EN defined: the CHECK state and the 8-bit additive checksum accumulator are built. One trailer byte per image is consumed and chk_err is live.
- ROM_LOADER_CHECKSUM_EN not defined: there is no CHECK state and no accumulator. DONE follows the last image byte and chk_err is tied to 0.

## Structure
- Package rom_loader_pkg holds:
  - the state encoding constants IDLE, LOAD, CHECK, DONE;
  - the byte-count width constant;
  - the checksum width (8).
- Sub-module rom_loader_cksum: 8-bit accumulator with clear and add-enable inputs, plus a zero-check output. It is instantiated only under ROM_LOADER_CHECKSUM_EN.

## Test plan
- Load with IMAGE_BYTES=4, BASE_ADDR=0x10: start, then bytes 0xA1, 0xB2, 0xC3, 0xD4 at gap 3 cycles. Expect writes to 0x10–0x13 with matching data, each one cycle after its strobe. done=1 and cpu_hold=0 two cycles after the last strobe.
- Back-to-back: 4 strobes on consecutive cycles. Expect 4 consecutive mem_we cycles and correct addresses.
- Ignored traffic:
  - strobes before start: no RAM writes;
  - a 5th strobe after DONE: no write;
  - start during LOAD: count continues unchanged.
- Checksum (macro defined):
  - bytes 0x01, 0x02, 0x03, 0x04, then trailer 0xF6: chk_err=0;
  - the same bytes with trailer 0xF7: chk_err=1;
  - the trailer is never written to RAM.
- Reset mid-load:
  - reset low after 2 bytes: all outputs return to reset values and cpu_hold=1;
  - a new start reloads from BASE_ADDR.
- Address wrap: ADDR_W=2, BASE_ADDR=3, IMAGE_BYTES=2. Expect writes to addresses 3 then 0.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM image loader: FSM states, byte-count and checksum widths.
// The CHECK state exists only when ROM_LOADER_CHECKSUM_EN is defined.
package rom_loader_pkg;

  localparam int CNT_W   = 15;
  localparam int CKSUM_W = 8;

`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/rom_loader_cksum.sv
// 8-bit additive checksum accumulator with clear and add-enable.
// zero_o reports whether the running sum plus the byte on data_i is zero mod 256.
module rom_loader_cksum
  import rom_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               add_i,
  input  logic [CKSUM_W-1:0] data_i,
  output logic               zero_o
);

  logic [CKSUM_W-1:0] sum_q, sum_d;
  logic [CKSUM_W-1:0] sum_with_data;

  assign sum_with_data = sum_q + data_i;
  assign zero_o        = (sum_with_data == '0);

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_with_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Copies the flash byte stream into the C64 ROM block RAM and holds the CPU in reset until done.
// Optional trailer-byte checksum: define ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int IMAGE_BYTES = 16384,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              chk_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;
  logic              image_full;

  assign image_full = (cnt_q == CNT_W'(IMAGE_BYTES));

`ifdef ROM_LOADER_CHECKSUM_EN
  logic chk_err_q, chk_err_d;
  logic ck_clr, ck_add, ck_zero;

  rom_loader_cksum u_cksum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ck_clr),
    .add_i  (ck_add),
    .data_i (byte_data),
    .zero_o (ck_zero)
  );

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
    chk_err_d = chk_err_q;
    ck_clr    = 1'b0;
    ck_add    = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          chk_err_d = 1'b0;
          ck_clr    = 1'b0 | 1'b1;
`endif
        end
      end
      LOAD: begin
        // Completion is decided from the registered count, which puts done one cycle after the last write.
        if (image_full) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          if (byte_valid) begin
            state_d   = DONE;
            chk_err_d = !ck_zero;
          end else begin
            state_d = CHECK;
          end
`else
          state_d = DONE;
`endif
        end else if (byte_valid) begin
          we_d   = 1'b1;
          addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);
          data_d = byte_data;
          cnt_d  = cnt_q + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
          ck_add = 1'b1;
`endif
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) begin
          state_d   = DONE;
          chk_err_d = !ck_zero;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_we   = we_q;
  assign busy     = (state_q == LOAD)
`ifdef ROM_LOADER_CHECKSUM_EN
                  || (state_q == CHECK)
`endif
                  ;
  assign done     = (state_q == DONE);
  assign cpu_hold = (state_q != DONE);

endmodule
